ring_counter: RTL and testbench
===============================

// Module: ring_counter
// PURPOSE
//   Parameterised Johnson (twisted-ring) counter: a W = N/2 bit shift register
//   with the inverted MSB fed back into the LSB, cycling through N states.
//   Used as a compact N-phase sequencer / timing generator.
//   Advances one state per enabled clock; holds otherwise.
//   Decoded state index and terminal-count flag provided for downstream control.
// PARAMETERS
//   N   8   number of distinct states; must be even and >= 4 (compile-time error otherwise)
//   W   N/2 (localparam, not overridable)   width of q
// PORTS
//   clk     in   1          rising-edge clock
//   reset   in   1          asynchronous, active-low reset (0 = reset asserted)
//   en      in   1          count enable, sampled on rising clk
//   q       out  W          Johnson-code state (registered)
//   idx     out  clog2(N)   state index 0..N-1 decoded from q (combinational)
//   tc      out  1          terminal count: q is state N-1 AND en=1 (combinational)
//   Port declaration order is clk, en, q, reset, idx, tc, so positional
//   (clk, en, q) instances stay valid. Connect new instances by name.
// BEHAVIOUR
//   - reset=0 asynchronously forces q = 0 (all zeros); idx=0; tc=0. While
//     reset is held low, q stays 0 regardless of clk/en.
//   - Reset release is synchronous to the next rising clk; the first update
//     occurs on the first rising edge that has reset=1.
//   - Rising clk with reset=1, en=1: q <= {q[W-2:0], ~q[W-1]}.
//   - Rising clk with reset=1, en=0: q holds.
//   - Sequence for N=8 (q[3:0], idx): 0000/0, 0001/1, 0011/2, 0111/3,
//     1111/4, 1110/5, 1100/6, 1000/7, then 0000/0 (wrap, period N).
//   - Legal states: exactly the N patterns above (one contiguous run of ones
//     anchored at bit 0 or at bit W-1, or all 0 / all 1).
//   - idx decode: if q[W-1]=0, idx = popcount(q); else idx = N - popcount(q),
//     except all-ones -> W. Out-of-range never reached for legal q.
//   - Illegal q (e.g. from upset): on next rising clk, regardless of en,
//     q <= 0. Recovery takes exactly 1 cycle. idx for an illegal q is 0 and
//     tc is 0.
//   - tc = en & (q == {1'b1, {W-1{1'b0}}}); high in the cycle whose edge
//     wraps q to 0.
//   - Latency: q changes one clk after en is sampled high; no pipeline.
//   - Reset mid-sequence: q immediately 0; counting resumes from state 0.
// TESTING
//   1. reset=0 for 10 clk, en=0 -> q=0000, idx=0, tc=0 throughout.
//   2. reset=1, en=1 for 100 clk -> q follows 0000,0001,0011,...,1000 with
//      period 8; idx = cycle count mod 8.
//   3. en=1, tc=1 exactly when q=1000 (once every 8 clk, 12 pulses in 100
//      clk from state 0); after that edge q=0000.
//   4. Count to q=0111, drop en for 5 clk -> q stays 0111, tc=0; raise en
//      -> next q=1111.
//   5. At q=1110, pulse reset low between edges -> q=0000 immediately
//      (asynchronous); release; next enabled edge -> 0001.
//   6. Force q=0101 (illegal), en=0 -> after one rising clk q=0000, idx=0.

Source files
------------

// File: rtl/ring_counter.sv
// Johnson (twisted-ring) counter: N states held in an N/2-bit register, with state-index decode and terminal count.
// Illegal codes collapse to all-zero on the next clock regardless of enable; no pipeline, holds when en is low.
module ring_counter #(
   parameter  int N  = 8,
   localparam int W  = N / 2,
   localparam int IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          en,
   output logic [W-1:0]  q,
   input  logic          reset,
   output logic [IW-1:0] idx,
   output logic          tc
);

   generate
      if ((N < 4) || ((N % 2) != 0)) begin : g_bad_n
         $error("ring_counter: N must be even and >= 4");
      end
   endgenerate

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;
   logic [W-1:0] inv_q;
   logic         low_run;
   logic         high_run;
   logic         legal;
   int unsigned  pop;

   // A legal code is a single run of ones anchored at bit 0, or a run of zeros anchored at bit 0.
   always_comb begin
      inv_q    = ~q_q;
      low_run  = ((q_q & (q_q + W'(1))) == '0);
      high_run = ((inv_q & (inv_q + W'(1))) == '0);
      legal    = low_run | high_run;
      pop      = $countones(q_q);

      idx = '0;
      if (legal) begin
         if (!q_q[W-1]) begin
            idx = IW'(pop);
         end else if (&q_q) begin
            idx = IW'(W);
         end else begin
            idx = IW'(N - int'(pop));
         end
      end

      tc = en & (q_q == {1'b1, {(W-1){1'b0}}});

      q_d = q_q;
      if (!legal) begin
         q_d = '0;
      end else if (en) begin
         q_d = {q_q[W-2:0], ~q_q[W-1]};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: tb/tb_ring_counter.sv
// Bench for ring_counter (N=8): state-number model compared every cycle, plus directed literal checks.
module tb_ring_counter;

   localparam int N  = 8;
   localparam int W  = N / 2;
   localparam int IW = $clog2(N);

   logic          clk;
   logic          en;
   logic          reset;
   logic [W-1:0]  q;
   logic [IW-1:0] idx;
   logic          tc;

   int errors = 0;
   int checks = 0;

   // Model: plain state number 0..N-1 and an "illegal code injected" flag.
   int m_s = 0;
   bit inj = 1'b0;
   int tc_pulses = 0;

   ring_counter #(.N(N)) dut (
      .clk   (clk),
      .en    (en),
      .q     (q),
      .reset (reset),
      .idx   (idx),
      .tc    (tc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] jpat(input int s);
      int k;
      logic [W-1:0] ones;
      if (s <= W) begin
         ones = W'((1 << s) - 1);
         return ones;
      end
      k    = N - s;
      ones = W'((1 << k) - 1);
      return ones << (W - k);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_s <= 0;
      end else if (inj) begin
         m_s <= 0;
      end else if (en) begin
         m_s <= (m_s + 1) % N;
      end
   end

   always @(negedge clk) begin
      check("model_q",   int'(q),   int'(jpat(m_s)));
      check("model_idx", int'(idx), m_s);
      check("model_tc",  int'(tc),  int'(en && (m_s == N - 1)));
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0;
      en    = 1'b0;

      // Held in reset for 10 clocks with en low.
      repeat (10) @(posedge clk);
      #1;
      check("rst_q",   int'(q),   0);
      check("rst_idx", int'(idx), 0);
      check("rst_tc",  int'(tc),  0);

      // Free-running for 100 clocks from state 0; tc must fire at each q=1000.
      reset = 1'b1;
      en    = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tc) begin
            tc_pulses++;
            check("tc_at_1000", int'(q), 8);
         end
         if (i == 4) check("lit_q_1111", int'(q), 15);
         if (i == 6) check("lit_q_1100", int'(q), 12);
      end
      check("tc_pulse_count", tc_pulses, 12);

      // 100 cycles leaves q at 0111; hold with en low for 5 clocks.
      #1;
      check("hold_start_q", int'(q), 7);
      en = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("hold_q",  int'(q),  7);
      check("hold_tc", int'(tc), 0);
      en = 1'b1;
      @(posedge clk);
      #1;
      check("resume_q",   int'(q),   15);
      check("resume_idx", int'(idx), 4);

      // Asynchronous reset pulse between edges at q=1110.
      @(posedge clk);
      #1;
      check("pre_rst_q",   int'(q),   14);
      check("pre_rst_idx", int'(idx), 5);
      reset = 1'b0;
      #1;
      check("async_rst_q",   int'(q),   0);
      check("async_rst_idx", int'(idx), 0);
      #2;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_q", int'(q), 1);

      // Illegal code 0101 injected with en low: decodes to idx 0, clears on next edge.
      en = 1'b0;
      @(negedge clk);
      #1;
      force dut.q_q = 4'b0101;
      #1;
      release dut.q_q;
      inj = 1'b1;
      #1;
      check("illegal_idx", int'(idx), 0);
      check("illegal_tc",  int'(tc),  0);
      @(posedge clk);
      #1;
      inj = 1'b0;
      check("recover_q",   int'(q),   0);
      check("recover_idx", int'(idx), 0);

      // Run a full period more so the model comparisons cover the restart.
      en = 1'b1;
      repeat (N + 2) @(posedge clk);
      #1;
      check("final_q", int'(q), int'(jpat((N + 2) % N)));

      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
